// File: rtl/pll_video_ctrl_pkg.sv
// rtl/pll_video_ctrl_pkg.sv - state encoding and PLL port constants for pll_video_ctrl
// Build option: PLL_VIDEO_CTRL_WATCHDOG_EN adds the PLL_RESET state.
package pll_video_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_STABLE      = 3'd1,
        ST_RUN         = 3'd2,
        ST_STEP_SETUP  = 3'd3,
        ST_STEP_PULSE  = 3'd4,
        ST_STEP_SETTLE = 3'd5
`ifdef PLL_VIDEO_CTRL_WATCHDOG_EN
        ,
        ST_PLL_RESET   = 3'd6
`endif
    } state_e;

    localparam logic [1:0] PHASESEL_CLKOP  = 2'd0;
    localparam logic [1:0] PHASESEL_CLKOS  = 2'd1;
    localparam logic [1:0] PHASESEL_CLKOS2 = 2'd2;
    localparam logic [1:0] PHASESEL_CLKOS3 = 2'd3;

    localparam int PULSE_WIDTH   = 2;
    localparam int PLL_RST_WIDTH = 16;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with asynchronous active-low clear
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_video_ctrl.sv
// rtl/pll_video_ctrl.sv - PLL lock qualification, video reset release and PHASESTEP sequencing
// Build option: define PLL_VIDEO_CTRL_WATCHDOG_EN for the lock-timeout PLL reset retry.
module pll_video_ctrl
    import pll_video_ctrl_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STEP_SETTLE_CYCLES = 8,
    parameter int LOCK_TIMEOUT       = 65536
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic       req_dir,
    input  logic [3:0] req_steps,
    output logic [1:0] pll_phasesel,
    output logic       pll_phasedir,
    output logic       pll_phasestep,
    output logic       pll_phaseloadreg,
    output logic       pll_rst,
    output logic       video_reset_n,
    output logic       busy,
    output logic       lock_lost
);

    localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int CYC_MAX  = (STEP_SETTLE_CYCLES > PLL_RST_WIDTH) ? STEP_SETTLE_CYCLES : PLL_RST_WIDTH;
    localparam int CYC_W    = $clog2(CYC_MAX + 1);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_MAX  = STABLE_W'(LOCK_STABLE_CYCLES);
    localparam logic [CYC_W-1:0]    PULSE_LAST  = CYC_W'(PULSE_WIDTH - 1);
    localparam logic [CYC_W-1:0]    SETTLE_LAST = CYC_W'(STEP_SETTLE_CYCLES - 1);

    if (LOCK_STABLE_CYCLES < 1 || STEP_SETTLE_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_param_check
        $error("pll_video_ctrl: cycle-count parameters must be at least 1");
    end

    // Reset asserts asynchronously but is released on a clk edge.
    logic rst_n;
    logic lock_sync;

    sync_2ff u_rst_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (1'b1),
        .q     (rst_n)
    );

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_sync)
    );

    state_e              state_q, state_d;
    logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic [3:0]          steps_q, steps_d;
    logic [1:0]          sel_q, sel_d;
    logic                dir_q, dir_d;
    logic                lock_lost_q, lock_lost_d;
    logic                video_reset_n_q, video_reset_n_d;
    logic                phasestep_q, phasestep_d;
    logic                xfer;

`ifdef PLL_VIDEO_CTRL_WATCHDOG_EN
    localparam int                TO_W        = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0]  PLLRST_LAST = CYC_W'(PLL_RST_WIDTH - 1);
    logic [TO_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic            pll_rst_q, pll_rst_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_WAIT_LOCK;
            stable_cnt_q    <= '0;
            cyc_cnt_q       <= '0;
            steps_q         <= '0;
            sel_q           <= PHASESEL_CLKOP;
            dir_q           <= 1'b0;
            lock_lost_q     <= 1'b0;
            video_reset_n_q <= 1'b0;
            phasestep_q     <= 1'b1;
`ifdef PLL_VIDEO_CTRL_WATCHDOG_EN
            timeout_cnt_q   <= '0;
            pll_rst_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            stable_cnt_q    <= stable_cnt_d;
            cyc_cnt_q       <= cyc_cnt_d;
            steps_q         <= steps_d;
            sel_q           <= sel_d;
            dir_q           <= dir_d;
            lock_lost_q     <= lock_lost_d;
            video_reset_n_q <= video_reset_n_d;
            phasestep_q     <= phasestep_d;
`ifdef PLL_VIDEO_CTRL_WATCHDOG_EN
            timeout_cnt_q   <= timeout_cnt_d;
            pll_rst_q       <= pll_rst_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        steps_d      = steps_q;
        sel_d        = sel_q;
        dir_d        = dir_q;
        lock_lost_d  = lock_lost_q;
`ifdef PLL_VIDEO_CTRL_WATCHDOG_EN
        timeout_cnt_d = '0;
`endif
        unique case (state_q)
            ST_WAIT_LOCK: begin
                stable_cnt_d = '0;
                if (lock_sync) begin
                    // The first locked cycle already counts toward stability.
                    stable_cnt_d = STABLE_W'(1);
                    state_d      = (LOCK_STABLE_CYCLES <= 1) ? ST_RUN : ST_STABLE;
                end
`ifdef PLL_VIDEO_CTRL_WATCHDOG_EN
                else if (timeout_cnt_q >= TO_LAST) begin
                    state_d   = ST_PLL_RESET;
                    cyc_cnt_d = '0;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + 1'b1;
                end
`endif
            end
            ST_STABLE: begin
                if (!lock_sync) begin
                    state_d      = ST_WAIT_LOCK;
                    stable_cnt_d = '0;
                end else begin
                    if (stable_cnt_q != STABLE_MAX) begin
                        stable_cnt_d = stable_cnt_q + 1'b1;
                    end
                    if (stable_cnt_q >= STABLE_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (xfer && req_steps != 4'd0) begin
                    sel_d   = req_sel;
                    dir_d   = req_dir;
                    steps_d = req_steps;
                    state_d = ST_STEP_SETUP;
                end
            end
            ST_STEP_SETUP: begin
                state_d   = ST_STEP_PULSE;
                cyc_cnt_d = '0;
            end
            ST_STEP_PULSE: begin
                if (cyc_cnt_q >= PULSE_LAST) begin
                    state_d   = ST_STEP_SETTLE;
                    cyc_cnt_d = '0;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            ST_STEP_SETTLE: begin
                if (cyc_cnt_q >= SETTLE_LAST) begin
                    cyc_cnt_d = '0;
                    steps_d   = (steps_q != 4'd0) ? steps_q - 4'd1 : 4'd0;
                    state_d   = (steps_q <= 4'd1) ? ST_RUN : ST_STEP_SETUP;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
`ifdef PLL_VIDEO_CTRL_WATCHDOG_EN
            ST_PLL_RESET: begin
                if (cyc_cnt_q >= PLLRST_LAST) begin
                    state_d   = ST_WAIT_LOCK;
                    cyc_cnt_d = '0;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_WAIT_LOCK;
        endcase

        // Losing lock after release overrides everything; sel/dir keep their last values.
        if (!lock_sync && (state_q inside {ST_RUN, ST_STEP_SETUP, ST_STEP_PULSE, ST_STEP_SETTLE})) begin
            state_d      = ST_WAIT_LOCK;
            lock_lost_d  = 1'b1;
            steps_d      = '0;
            cyc_cnt_d    = '0;
            stable_cnt_d = '0;
        end

        video_reset_n_d = state_d inside {ST_RUN, ST_STEP_SETUP, ST_STEP_PULSE, ST_STEP_SETTLE};
        phasestep_d     = (state_d != ST_STEP_PULSE);
`ifdef PLL_VIDEO_CTRL_WATCHDOG_EN
        pll_rst_d       = (state_d == ST_PLL_RESET);
`endif
    end

    always_comb begin
        req_ready = (state_q == ST_RUN) && lock_sync;
        busy      = state_q inside {ST_STEP_SETUP, ST_STEP_PULSE, ST_STEP_SETTLE};
    end

    assign xfer             = req_valid && req_ready;
    assign pll_phasesel     = sel_q;
    assign pll_phasedir     = dir_q;
    assign pll_phasestep    = phasestep_q;
    assign pll_phaseloadreg = 1'b1;
    assign video_reset_n    = video_reset_n_q;
    assign lock_lost        = lock_lost_q;
`ifdef PLL_VIDEO_CTRL_WATCHDOG_EN
    assign pll_rst          = pll_rst_q;
`else
    assign pll_rst          = 1'b0;
`endif

endmodule

// File: tb/tb_pll_video_ctrl.sv
// tb/tb_pll_video_ctrl.sv - self-checking bench for pll_video_ctrl
module tb_pll_video_ctrl;

    localparam int N_STABLE  = 16;
    localparam int N_SETTLE  = 8;
    localparam int N_TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_sel = 2'd0;
    logic       req_dir = 1'b0;
    logic [3:0] req_steps = 4'd0;
    logic [1:0] pll_phasesel;
    logic       pll_phasedir;
    logic       pll_phasestep;
    logic       pll_phaseloadreg;
    logic       pll_rst;
    logic       video_reset_n;
    logic       busy;
    logic       lock_lost;

    always #5 clk = ~clk;

    pll_video_ctrl #(
        .LOCK_STABLE_CYCLES (N_STABLE),
        .STEP_SETTLE_CYCLES (N_SETTLE),
        .LOCK_TIMEOUT       (N_TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pll_locked       (pll_locked),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_sel          (req_sel),
        .req_dir          (req_dir),
        .req_steps        (req_steps),
        .pll_phasesel     (pll_phasesel),
        .pll_phasedir     (pll_phasedir),
        .pll_phasestep    (pll_phasestep),
        .pll_phaseloadreg (pll_phaseloadreg),
        .pll_rst          (pll_rst),
        .video_reset_n    (video_reset_n),
        .busy             (busy),
        .lock_lost        (lock_lost)
    );

    typedef struct {
        logic [1:0] sel;
        logic       dir;
        int         width;
    } pulse_t;

    pulse_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_release(input string tag);
        int cyc = 0;
        while (video_reset_n !== 1'b1 && cyc < 200) begin
            tick(1);
            cyc++;
        end
        check(tag, cyc, N_STABLE + 2);
    endtask

    task automatic push_pulse(input logic [1:0] sel, input logic dir, input int width);
        pulse_t p;
        p.sel   = sel;
        p.dir   = dir;
        p.width = width;
        exp_q.push_back(p);
    endtask

    task automatic do_req(input logic [1:0] sel, input logic dir, input logic [3:0] steps);
        check("req_ready_before_request", req_ready, 1);
        req_valid = 1'b1;
        req_sel   = sel;
        req_dir   = dir;
        req_steps = steps;
        tick(1);
        req_valid = 1'b0;
    endtask

    // Pulse monitor: every completed low pulse on PHASESTEP is matched against the scoreboard.
    initial begin
        int run = 0;
        pulse_t e;
        forever begin
            @(posedge clk);
            #1;
            if (pll_phasestep === 1'b0) begin
                run++;
            end else if (run > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_phasestep_pulse", run, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_width", run, e.width);
                    check("pulse_phasesel", pll_phasesel, e.sel);
                    check("pulse_phasedir", pll_phasedir, e.dir);
                end
                run = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int seen;
        int hi;
        int per;

        #2;
        reset_n = 1'b0;
        tick(3);
        check("rst_video_reset_n", video_reset_n, 0);
        check("rst_pll_rst", pll_rst, 0);
        check("rst_phasestep", pll_phasestep, 1);
        check("rst_phaseloadreg", pll_phaseloadreg, 1);
        check("rst_phasesel", pll_phasesel, 0);
        check("rst_phasedir", pll_phasedir, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_lock_lost", lock_lost, 0);

        // Lock rises at cycle 10 after release.
        reset_n = 1'b1;
        tick(10);
        pll_locked = 1'b1;
        wait_release("lock_release_latency");
        check("ready_after_release", req_ready, 1);

        // Three steps on CLKOS, lag direction.
        for (int i = 0; i < 3; i++) push_pulse(2'd1, 1'b1, 2);
        do_req(2'd1, 1'b1, 4'd3);
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            tick(1);
        end
        check("busy_cycles_3_steps", busy_cnt, 3 * (1 + 2 + N_SETTLE));
        check("phasesel_held", pll_phasesel, 1);
        check("phasedir_held", pll_phasedir, 1);
        check("ready_after_sequence", req_ready, 1);
        check("pulses_outstanding", exp_q.size(), 0);

        // Zero-step request is accepted but does nothing.
        do_req(2'd2, 1'b0, 4'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy !== 1'b0) seen++;
        end
        check("steps0_busy", seen, 0);
        check("steps0_ready", req_ready, 1);
        check("steps0_phasesel_unchanged", pll_phasesel, 1);

        // Lock drops so the synchronized lock is low during the second pulse.
        push_pulse(2'd2, 1'b0, 2);
        push_pulse(2'd2, 1'b0, 1);
        do_req(2'd2, 1'b0, 4'd3);
        tick(10);
        pll_locked = 1'b0;
        tick(2);
        check("abort_second_pulse_low", pll_phasestep, 0);
        tick(1);
        check("abort_phasestep_high", pll_phasestep, 1);
        check("abort_video_reset_n", video_reset_n, 0);
        check("abort_lock_lost", lock_lost, 1);
        check("abort_busy", busy, 0);
        check("abort_req_ready", req_ready, 0);
        tick(4);
        check("abort_pulses_outstanding", exp_q.size(), 0);
        pll_locked = 1'b1;
        wait_release("relock_release_latency");
        check("lock_lost_sticky", lock_lost, 1);

        // Asynchronous reset while settling after the first of two steps.
        push_pulse(2'd3, 1'b1, 2);
        do_req(2'd3, 1'b1, 4'd2);
        tick(5);
        check("midseq_busy", busy, 1);
        #3;
        reset_n = 1'b0;
        pll_locked = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_video_reset_n", video_reset_n, 0);
        check("async_rst_lock_lost", lock_lost, 0);
        check("async_rst_phasesel", pll_phasesel, 0);
        check("async_rst_phasestep", pll_phasestep, 1);
        tick(3);
        check("midseq_pulses_outstanding", exp_q.size(), 0);

        // One-cycle lock glitch restarts the stability count.
        reset_n = 1'b1;
        tick(5);
        pll_locked = 1'b1;
        tick(8);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        wait_release("glitch_release_latency");
        check("glitch_lock_lost", lock_lost, 0);

        // Lock held low from reset.
        reset_n = 1'b0;
        pll_locked = 1'b0;
        tick(3);
        reset_n = 1'b1;
`ifdef PLL_VIDEO_CTRL_WATCHDOG_EN
        per = 0;
        while (pll_rst !== 1'b1 && per < 400) begin
            tick(1);
            per++;
        end
        check("wd_first_pll_rst_seen", (per < 400), 1);
        hi = 0;
        while (pll_rst === 1'b1 && hi < 100) begin
            tick(1);
            hi++;
        end
        check("wd_pll_rst_width", hi, 16);
        per = hi;
        while (pll_rst !== 1'b1 && per < 400) begin
            tick(1);
            per++;
        end
        check("wd_pll_rst_period", per, N_TIMEOUT + 16);
        check("wd_video_reset_n", video_reset_n, 0);
`else
        hi = 0;
        per = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (pll_rst !== 1'b0) hi++;
            if (video_reset_n !== 1'b0) per++;
        end
        check("no_wd_pll_rst_low", hi, 0);
        check("no_wd_video_held", per, 0);
`endif
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
